bitwise_xor_core: RTL and testbench



---
 rtl/bitwise_xor_core.sv | 87 ++++++++
 tb/tb_bitwise_xor_core.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_xor_core.sv
// Registered bitwise XOR with zero/parity condition flags and one-cycle latency.
// Optional BXOR_POPCOUNT_EN adds a registered ones_count output.
module bitwise_xor_core #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] bxor_out,
    output logic             out_valid,
    output logic             zero,
    output logic             parity
`ifdef BXOR_POPCOUNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] ones_count
`endif
);

    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] bxor_d, bxor_q;
    logic             valid_d, valid_q;
    logic             zero_d, zero_q;
    logic             parity_d, parity_q;

    // Operand values only reach the registers through the in_valid mux,
    // so undefined operands while idle never disturb the held outputs.
    always_comb begin
        result   = in1 ^ in2;
        bxor_d   = bxor_q;
        zero_d   = zero_q;
        parity_d = parity_q;
        valid_d  = 1'b0;
        if (in_valid) begin
            bxor_d   = result;
            zero_d   = (result == '0);
            parity_d = ^result;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bxor_q   <= '0;
            valid_q  <= 1'b0;
            zero_q   <= 1'b1;
            parity_q <= 1'b0;
        end else begin
            bxor_q   <= bxor_d;
            valid_q  <= valid_d;
            zero_q   <= zero_d;
            parity_q <= parity_d;
        end
    end

    assign bxor_out  = bxor_q;
    assign out_valid = valid_q;
    assign zero      = zero_q;
    assign parity    = parity_q;

`ifdef BXOR_POPCOUNT_EN
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [CW-1:0] pop;
    logic [CW-1:0] ones_d, ones_q;

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pop = pop + CW'(result[i]);
        end
        ones_d = in_valid ? pop : ones_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ones_q <= '0;
        end else begin
            ones_q <= ones_d;
        end
    end

    assign ones_count = ones_q;
`endif

endmodule

// File: tb/tb_bitwise_xor_core.sv
// Self-checking bench for bitwise_xor_core (WIDTH=4): directed, sweep and random
// stimulus against a bit-counting reference model.
module tb_bitwise_xor_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in1 = '0;
    logic [3:0] in2 = '0;
    logic [3:0] bxor_out;
    logic       out_valid;
    logic       zero;
    logic       parity;
`ifdef BXOR_POPCOUNT_EN
    logic [2:0] ones_count;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state: what the outputs should show after the last edge.
    logic [3:0]  m_out = '0;
    logic        m_valid = 1'b0;
    logic        m_zero = 1'b1;
    logic        m_par = 1'b0;
    int unsigned m_cnt = 0;

    bitwise_xor_core #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in1       (in1),
        .in2       (in2),
        .bxor_out  (bxor_out),
        .out_valid (out_valid),
        .zero      (zero),
        .parity    (parity)
`ifdef BXOR_POPCOUNT_EN
        ,
        .ones_count(ones_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic int unsigned count_ones(input logic [3:0] v);
        int unsigned n = 0;
        for (int i = 0; i < 4; i++) if (v[i] == 1'b1) n++;
        return n;
    endfunction

    // Drive one cycle, then advance the model by the rules of the block.
    task automatic step(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b);
        int unsigned n;
        rst = r; in_valid = v; in1 = a; in2 = b;
        @(posedge clk);
        #1;
        if (r) begin
            m_out = 4'd0; m_valid = 1'b0; m_zero = 1'b1; m_par = 1'b0; m_cnt = 0;
        end else if (v) begin
            m_out   = a ^ b;
            n       = count_ones(m_out);
            m_zero  = (n == 0);
            m_par   = (n % 2) == 1;
            m_cnt   = n;
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    task automatic test_reset;
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b1, 4'b1111, 4'b0000);
            checks++;
            if ({out_valid, zero, parity, bxor_out} !== 7'b0_1_0_0000) begin
                errors++;
                $display("FAIL reset[%0d]: got v/z/p/out=%b required 0100000", k,
                         {out_valid, zero, parity, bxor_out});
            end
        end
    endtask

    task automatic test_directed;
        logic [3:0] a_t [5] = '{4'b0100, 4'b0100, 4'b0101, 4'b1111, 4'b1000};
        logic [3:0] b_t [5] = '{4'b0011, 4'b0101, 4'b0101, 4'b1000, 4'b1111};
        logic [3:0] o_t [5] = '{4'b0111, 4'b0001, 4'b0000, 4'b0111, 4'b0111};
        logic       z_t [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       p_t [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, a_t[k], b_t[k]);
            checks++;
            if ({out_valid, zero, parity, bxor_out} !== {1'b1, z_t[k], p_t[k], o_t[k]}) begin
                errors++;
                $display("FAIL directed[%0d]: got v/z/p/out=%b required %b", k,
                         {out_valid, zero, parity, bxor_out}, {1'b1, z_t[k], p_t[k], o_t[k]});
            end
        end
    endtask

    task automatic test_hold;
        step(1'b0, 1'b1, 4'b0100, 4'b0101);
        for (int k = 0; k < 5; k++) begin
            if (k < 3) step(1'b0, 1'b0, 4'b1111, 4'b0000);
            else       step(1'b0, 1'b0, 4'bxxxx, 4'bxxxx);
            checks++;
            if ({out_valid, zero, parity, bxor_out} !== 7'b0_0_1_0001) begin
                errors++;
                $display("FAIL hold[%0d]: got v/z/p/out=%b required 0010001", k,
                         {out_valid, zero, parity, bxor_out});
            end
        end
    endtask

    task automatic test_reset_midstream;
        step(1'b0, 1'b1, 4'b1100, 4'b0110);
        step(1'b1, 1'b1, 4'b1010, 4'b0101);
        checks++;
        if ({out_valid, zero, parity, bxor_out} !== 7'b0_1_0_0000) begin
            errors++;
            $display("FAIL rst_mid: got v/z/p/out=%b required 0100000", {out_valid, zero, parity, bxor_out});
        end
        step(1'b0, 1'b0, 4'b1010, 4'b0101);
        checks++;
        if ({out_valid, zero, parity, bxor_out} !== 7'b0_1_0_0000) begin
            errors++;
            $display("FAIL rst_mid_idle: got v/z/p/out=%b required 0100000", {out_valid, zero, parity, bxor_out});
        end
        step(1'b0, 1'b1, 4'b0011, 4'b0000);
        checks++;
        if ({out_valid, zero, parity, bxor_out} !== 7'b1_0_0_0011) begin
            errors++;
            $display("FAIL rst_mid_first: got v/z/p/out=%b required 1000011", {out_valid, zero, parity, bxor_out});
        end
    endtask

    task automatic test_sweep;
        logic [3:0] res [256];
        logic [3:0] a, b;
        for (int i = 0; i < 256; i++) begin
            a = 4'(i / 16); b = 4'(i % 16);
            step(1'b0, 1'b1, a, b);
            res[i] = bxor_out;
            checks++;
            if ({out_valid, zero, parity, bxor_out} !== {m_valid, m_zero, m_par, m_out}) begin
                errors++;
                $display("FAIL sweep(%b,%b): got v/z/p/out=%b required %b", a, b,
                         {out_valid, zero, parity, bxor_out}, {m_valid, m_zero, m_par, m_out});
            end
            if (a == b) begin
                checks++;
                if (zero !== 1'b1 || bxor_out !== 4'b0000) begin
                    errors++;
                    $display("FAIL self_xor(%b): got z/out=%b%b required 10000", a, zero, bxor_out);
                end
            end
            if (b == 4'b0000) begin
                checks++;
                if (bxor_out !== a) begin
                    errors++;
                    $display("FAIL identity(%b): got %b required %b", a, bxor_out, a);
                end
            end
        end
        for (int i = 0; i < 256; i++) begin
            if (i / 16 < i % 16) begin
                checks++;
                if (res[i] !== res[(i % 16) * 16 + i / 16]) begin
                    errors++;
                    $display("FAIL commute(%0d,%0d): got %b required %b", i / 16, i % 16,
                             res[i], res[(i % 16) * 16 + i / 16]);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] a, b;
        for (int k = 0; k < 16; k++) begin
            a = 4'($urandom); b = 4'($urandom);
            step(1'b0, 1'b1, a, b);
            checks++;
            if ({out_valid, zero, parity, bxor_out} !== {1'b1, m_zero, m_par, m_out}) begin
                errors++;
                $display("FAIL b2b[%0d]: got v/z/p/out=%b required %b", k,
                         {out_valid, zero, parity, bxor_out}, {1'b1, m_zero, m_par, m_out});
            end
        end
    endtask

    task automatic test_random;
        logic r, v;
        logic [3:0] a, b;
        for (int k = 0; k < 300; k++) begin
            r = ($urandom_range(0, 19) == 0);
            v = $urandom_range(0, 2) != 0;
            a = 4'($urandom); b = 4'($urandom);
            step(r, v, a, b);
            checks++;
            if ({out_valid, zero, parity, bxor_out} !== {m_valid, m_zero, m_par, m_out}) begin
                errors++;
                $display("FAIL random[%0d]: got v/z/p/out=%b required %b", k,
                         {out_valid, zero, parity, bxor_out}, {m_valid, m_zero, m_par, m_out});
            end
`ifdef BXOR_POPCOUNT_EN
            checks++;
            if (ones_count !== 3'(m_cnt)) begin
                errors++;
                $display("FAIL random_cnt[%0d]: got %0d required %0d", k, ones_count, m_cnt);
            end
`endif
        end
    endtask

`ifdef BXOR_POPCOUNT_EN
    task automatic test_popcount;
        logic [3:0] a_t [3] = '{4'b1111, 4'b0100, 4'b0101};
        logic [3:0] b_t [3] = '{4'b0000, 4'b0011, 4'b0101};
        logic [2:0] c_t [3] = '{3'd4, 3'd3, 3'd0};
        step(1'b1, 1'b1, 4'b1111, 4'b0000);
        checks++;
        if (ones_count !== 3'd0) begin
            errors++;
            $display("FAIL cnt_reset: got %0d required 0", ones_count);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, a_t[k], b_t[k]);
            checks++;
            if (ones_count !== c_t[k]) begin
                errors++;
                $display("FAIL cnt[%0d]: got %0d required %0d", k, ones_count, c_t[k]);
            end
        end
        step(1'b0, 1'b1, 4'b1110, 4'b0000);
        step(1'b0, 1'b0, 4'b1111, 4'b0000);
        checks++;
        if (ones_count !== 3'd3) begin
            errors++;
            $display("FAIL cnt_hold: got %0d required 3", ones_count);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_directed;
        test_hold;
        test_reset_midstream;
        test_sweep;
        test_back_to_back;
        test_random;
`ifdef BXOR_POPCOUNT_EN
        test_popcount;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish within 200000 time units required finish");
        $fatal(1);
    end

endmodule
